// File: rtl/sb_tx_arbiter.sv
// Round-robin arbiter sharing the sideband TX encoder between LTSM sub-state controllers.
// Optional watchdog abort is enabled by defining SB_ARB_TIMEOUT_EN.
module sb_tx_arbiter #(
   parameter int N_REQ          = 4,
   parameter int SB_MSG_WIDTH   = 4,
   parameter int TIMEOUT_CYCLES = 8000,
   parameter int TO_W           = 14
) (
   input  logic                          i_clk,
   input  logic                          i_rst_n,
   input  logic [N_REQ-1:0]              i_req_valid,
   input  logic [N_REQ*SB_MSG_WIDTH-1:0] i_req_msg,
   input  logic                          i_sb_busy,
   output logic [SB_MSG_WIDTH-1:0]       o_sb_msg,
   output logic                          o_sb_valid,
   output logic [N_REQ-1:0]              o_grant,
   output logic [N_REQ-1:0]              o_done,
   output logic                          o_timeout
);

   localparam int PTR_W = (N_REQ > 2) ? $clog2(N_REQ) : 1;

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_LAUNCH  = 2'd1;
   localparam logic [1:0] S_WAIT    = 2'd2;
   localparam logic [1:0] S_RELEASE = 2'd3;

   logic [1:0]              state;
   logic [PTR_W-1:0]        rr_ptr;
   logic [PTR_W-1:0]        owner;
   logic [PTR_W-1:0]        nxt_ptr;
   logic [PTR_W-1:0]        pick;
   logic [PTR_W:0]          cand;
   logic                    found;
   logic [SB_MSG_WIDTH-1:0] sel_msg;
   logic                    busy_d;
   logic                    active;
   logic                    to_hit;

   // Scan from rr_ptr upward, wrapping, and take the first valid requester.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      cand  = '0;
      for (int i = 0; i < N_REQ; i++) begin
         cand = {1'b0, rr_ptr} + (PTR_W+1)'(i);
         if (cand >= (PTR_W+1)'(N_REQ))
            cand = cand - (PTR_W+1)'(N_REQ);
         if (!found && i_req_valid[cand[PTR_W-1:0]]) begin
            found = 1'b1;
            pick  = cand[PTR_W-1:0];
         end
      end
   end

   always_comb begin
      sel_msg = '0;
      for (int j = 0; j < N_REQ; j++) begin
         if (PTR_W'(j) == pick)
            sel_msg = i_req_msg[j*SB_MSG_WIDTH +: SB_MSG_WIDTH];
      end
   end

   assign nxt_ptr = (owner == PTR_W'(N_REQ-1)) ? '0 : owner + 1'b1;
   assign active  = (state == S_LAUNCH) || (state == S_WAIT);

`ifdef SB_ARB_TIMEOUT_EN
   logic [TO_W-1:0] to_cnt;
   logic            to_q;

   assign to_hit    = active && (to_cnt == TO_W'(TIMEOUT_CYCLES-1));
   assign o_timeout = to_q;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         to_cnt <= '0;
         to_q   <= 1'b0;
      end else begin
         to_q <= to_hit;
         if (active)
            to_cnt <= to_cnt + 1'b1;
         else
            to_cnt <= '0;
      end
   end
`else
   assign to_hit    = 1'b0;
   assign o_timeout = 1'b0;
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         busy_d <= 1'b0;
      else
         busy_d <= i_sb_busy;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state      <= S_IDLE;
         rr_ptr     <= '0;
         owner      <= '0;
         o_grant    <= '0;
         o_sb_msg   <= '0;
         o_sb_valid <= 1'b0;
         o_done     <= '0;
      end else begin
         o_done <= '0;
         unique case (state)
            S_IDLE: begin
               if (found) begin
                  owner      <= pick;
                  o_grant    <= {{(N_REQ-1){1'b0}}, 1'b1} << pick;
                  o_sb_msg   <= sel_msg;
                  o_sb_valid <= 1'b1;
                  state      <= S_LAUNCH;
               end
            end
            S_LAUNCH: begin
               if (to_hit) begin
                  o_grant    <= '0;
                  o_sb_valid <= 1'b0;
                  rr_ptr     <= nxt_ptr;
                  state      <= S_RELEASE;
               end else if (i_sb_busy) begin
                  o_sb_valid <= 1'b0;
                  state      <= S_WAIT;
               end else if (!i_req_valid[owner]) begin
                  // Withdrawn before acceptance: the owner keeps its turn.
                  o_grant    <= '0;
                  o_sb_valid <= 1'b0;
                  state      <= S_RELEASE;
               end
            end
            S_WAIT: begin
               if (to_hit) begin
                  o_grant <= '0;
                  rr_ptr  <= nxt_ptr;
                  state   <= S_RELEASE;
               end else if (busy_d && !i_sb_busy) begin
                  o_done  <= o_grant;
                  o_grant <= '0;
                  rr_ptr  <= nxt_ptr;
                  state   <= S_RELEASE;
               end
            end
            S_RELEASE: state <= S_IDLE;
            default:   state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sb_tx_arbiter.sv
// Directed testbench for sb_tx_arbiter (4 requesters, 4-bit codes).
// Watchdog scenario runs only when SB_ARB_TIMEOUT_EN is defined.
module tb_sb_tx_arbiter;

   logic        clk;
   logic        rst_n;
   logic [3:0]  req_valid;
   logic [15:0] req_msg;
   logic        sb_busy;
   logic [3:0]  sb_msg;
   logic        sb_valid;
   logic [3:0]  grant;
   logic [3:0]  done;
   logic        timeout;

   int checks;
   int failures;

   sb_tx_arbiter #(
      .N_REQ(4), .SB_MSG_WIDTH(4), .TIMEOUT_CYCLES(16), .TO_W(14)
   ) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid),
      .i_req_msg(req_msg), .i_sb_busy(sb_busy), .o_sb_msg(sb_msg),
      .o_sb_valid(sb_valid), .o_grant(grant), .o_done(done),
      .o_timeout(timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic serve(input int len);
      sb_busy = 1'b1;
      repeat (len) tick();
      sb_busy = 1'b0;
      tick();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req_valid = '0;
      req_msg = '0;
      sb_busy = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      req_valid = '0;
      req_msg = '0;
      sb_busy = 1'b0;
      tick();
      checks++;
      if ({grant, done, sb_msg, sb_valid, timeout} !== 14'd0) begin
         failures++;
         $display("FAIL reset_outputs got=%h exp=0",
                  {grant, done, sb_msg, sb_valid, timeout});
      end
      rst_n = 1'b1;
      tick();
      checks++;
      if (grant !== 4'b0000) begin
         failures++;
         $display("FAIL reset_idle_grant got=%b exp=0000", grant);
      end
   endtask

   task automatic test_single();
      int bad;
      req_valid = 4'b0100;
      req_msg = 16'h0300;
      tick();
      checks++;
      if ({grant, sb_msg, sb_valid} !== {4'b0100, 4'd3, 1'b1}) begin
         failures++;
         $display("FAIL single_grant got=%b/%h/%b exp=0100/3/1",
                  grant, sb_msg, sb_valid);
      end
      sb_busy = 1'b1;
      tick();
      checks++;
      if ({grant, sb_valid} !== {4'b0100, 1'b0}) begin
         failures++;
         $display("FAIL single_accept got=%b/%b exp=0100/0", grant, sb_valid);
      end
      bad = 0;
      repeat (9) begin
         tick();
         if (done !== 4'b0000 || grant !== 4'b0100) bad++;
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL single_hold got=%0d_bad_cycles exp=0", bad);
      end
      sb_busy = 1'b0;
      tick();
      checks++;
      if ({done, grant} !== {4'b0100, 4'b0000}) begin
         failures++;
         $display("FAIL single_done got=%b/%b exp=0100/0000", done, grant);
      end
      req_valid = '0;
      tick();
      checks++;
      if (done !== 4'b0000) begin
         failures++;
         $display("FAIL single_done_pulse got=%b exp=0000", done);
      end
   endtask

   task automatic test_wrap();
      req_valid = 4'b0011;
      req_msg = 16'h0065;
      tick();
      checks++;
      if ({grant, sb_msg} !== {4'b0001, 4'd5}) begin
         failures++;
         $display("FAIL wrap_first got=%b/%h exp=0001/5", grant, sb_msg);
      end
      serve(3);
      checks++;
      if (done !== 4'b0001) begin
         failures++;
         $display("FAIL wrap_done0 got=%b exp=0001", done);
      end
      req_valid = 4'b0010;
      tick();
      checks++;
      if (grant !== 4'b0000) begin
         failures++;
         $display("FAIL wrap_gap got=%b exp=0000", grant);
      end
      tick();
      checks++;
      if ({grant, sb_msg} !== {4'b0010, 4'd6}) begin
         failures++;
         $display("FAIL wrap_second got=%b/%h exp=0010/6", grant, sb_msg);
      end
      serve(2);
      checks++;
      if (done !== 4'b0010) begin
         failures++;
         $display("FAIL wrap_done1 got=%b exp=0010", done);
      end
      req_valid = '0;
      tick();
   endtask

   task automatic test_msg_hold();
      int bad;
      req_valid = 4'b0010;
      req_msg = 16'h0010;
      tick();
      checks++;
      if ({grant, sb_msg} !== {4'b0010, 4'd1}) begin
         failures++;
         $display("FAIL hold_grant got=%b/%h exp=0010/1", grant, sb_msg);
      end
      sb_busy = 1'b1;
      tick();
      req_msg = 16'h0020;
      bad = 0;
      repeat (3) begin
         tick();
         if (sb_msg !== 4'd1 || grant !== 4'b0010) bad++;
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL hold_msg got=%0d_bad_cycles exp=0", bad);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({grant, done, sb_msg, sb_valid} !== 13'd0) begin
         failures++;
         $display("FAIL async_reset got=%h exp=0",
                  {grant, done, sb_msg, sb_valid});
      end
      req_valid = '0;
      sb_busy = 1'b0;
      tick();
      checks++;
      if (done !== 4'b0000) begin
         failures++;
         $display("FAIL async_reset_done got=%b exp=0000", done);
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_withdraw();
      req_valid = 4'b0010;
      req_msg = 16'h0070;
      tick();
      checks++;
      if ({grant, sb_valid} !== {4'b0010, 1'b1}) begin
         failures++;
         $display("FAIL wd_grant got=%b/%b exp=0010/1", grant, sb_valid);
      end
      req_valid = 4'b0000;
      tick();
      checks++;
      if ({grant, sb_valid, done} !== {4'b0000, 1'b0, 4'b0000}) begin
         failures++;
         $display("FAIL wd_release got=%b/%b/%b exp=0000/0/0000",
                  grant, sb_valid, done);
      end
      tick();
      checks++;
      if ({grant, done} !== 8'd0) begin
         failures++;
         $display("FAIL wd_idle got=%b/%b exp=0000/0000", grant, done);
      end
      req_valid = 4'b0110;
      req_msg = 16'h0970;
      tick();
      checks++;
      if ({grant, sb_msg} !== {4'b0010, 4'd7}) begin
         failures++;
         $display("FAIL wd_ptr_kept got=%b/%h exp=0010/7", grant, sb_msg);
      end
      serve(2);
      checks++;
      if (done !== 4'b0010) begin
         failures++;
         $display("FAIL wd_done got=%b exp=0010", done);
      end
      req_valid = '0;
      tick();
   endtask

   task automatic test_back_to_back();
      int order [5] = '{0, 1, 2, 3, 0};
      logic [3:0] exp_g;
      req_valid = 4'b1111;
      req_msg = 16'hBA98;
      for (int i = 0; i < 5; i++) begin
         exp_g = 4'b0001 << order[i];
         if (i > 0) req_valid = 4'b1111;
         tick();
         checks++;
         if ({grant, sb_msg} !== {exp_g, 4'(order[i] + 8)}) begin
            failures++;
            $display("FAIL rr_grant%0d got=%b/%h exp=%b/%h", i, grant,
                     sb_msg, exp_g, 4'(order[i] + 8));
         end
         serve(5);
         checks++;
         if (done !== exp_g) begin
            failures++;
            $display("FAIL rr_done%0d got=%b exp=%b", i, done, exp_g);
         end
         if (i == 4) req_valid = '0;
         tick();
         checks++;
         if (grant !== 4'b0000) begin
            failures++;
            $display("FAIL rr_gap%0d got=%b exp=0000", i, grant);
         end
      end
      tick();
   endtask

`ifdef SB_ARB_TIMEOUT_EN
   task automatic test_timeout();
      int bad;
      sb_busy = 1'b1;
      req_valid = 4'b0011;
      req_msg = 16'h0054;
      tick();
      checks++;
      if ({grant, sb_msg} !== {4'b0010, 4'd5}) begin
         failures++;
         $display("FAIL to_grant got=%b/%h exp=0010/5", grant, sb_msg);
      end
      bad = 0;
      repeat (15) begin
         tick();
         if (timeout !== 1'b0 || done !== 4'b0000) bad++;
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL to_early got=%0d_bad_cycles exp=0", bad);
      end
      tick();
      checks++;
      if ({timeout, grant, sb_valid, done} !== {1'b1, 9'd0}) begin
         failures++;
         $display("FAIL to_pulse got=%b/%b/%b/%b exp=1/0000/0/0000",
                  timeout, grant, sb_valid, done);
      end
      req_valid = 4'b0001;
      tick();
      checks++;
      if ({timeout, done} !== 5'd0) begin
         failures++;
         $display("FAIL to_one_cycle got=%b/%b exp=0/0000", timeout, done);
      end
      tick();
      checks++;
      if ({grant, sb_msg} !== {4'b0001, 4'd4}) begin
         failures++;
         $display("FAIL to_next got=%b/%h exp=0001/4", grant, sb_msg);
      end
      sb_busy = 1'b0;
      req_valid = '0;
      do_reset();
   endtask
`endif

   initial begin
      checks = 0;
      failures = 0;
      rst_n = 1'b1;
      req_valid = '0;
      req_msg = '0;
      sb_busy = 1'b0;
      #2;
      test_reset();
      test_single();
      test_wrap();
      test_msg_hold();
      test_withdraw();
      do_reset();
      test_back_to_back();
`ifdef SB_ARB_TIMEOUT_EN
      test_timeout();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
